// File: rtl/cache_set.sv
// cache_set: one set of an 8-way, 64-byte-line L1 data cache (tag/valid/dirty/LRU + line data).
// Ports: clk/reset; enable[0] accepts an op; write_en selects read/write/no-op; block_offset,
//        data_size, write_data, tag describe the access; out_data/miss_r/miss_w/data_ready report it.
// Latency: 1 cycle, registered results; an op may be accepted every cycle. set_n/num_ops are debug only.
module cache_set (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   enable,
  input  logic [2:0]   write_en,
  input  logic [5:0]   block_offset,
  input  logic [5:0]   set_n,
  input  logic [63:0]  write_data,
  input  logic [1:0]   data_size,
  input  logic [23:0]  tag,
  input  logic [31:0]  num_ops,
  output logic [127:0] out_data,
  output logic [1:0]   miss_w,
  output logic [1:0]   miss_r,
  output logic [1:0]   data_ready
);

  localparam int WAYS = 8;

  logic [WAYS-1:0] valid_q;
  logic [WAYS-1:0] dirty_q;
  logic [23:0]     tag_q  [WAYS];
  logic [511:0]    line_q [WAYS];
  logic [2:0]      age_q  [WAYS];

  logic [63:0] rd_q;
  logic        miss_r_q;
  logic        miss_w_q;
  logic        rdy_q;

  // Debug-only inputs and the ignored enable bit.
  logic unused_dbg;
  assign unused_dbg = ^{set_n, num_ops, enable[1]};

  // Lookup, victim choice and datapath.
  logic         hit;
  logic [2:0]   hit_way;
  logic         has_invalid;
  logic [2:0]   inv_way;
  logic [2:0]   lru_way;
  logic [2:0]   acc_way;
  logic [2:0]   old_age;
  logic [63:0]  size_mask;
  logic [8:0]   bit_shift;
  logic [511:0] base_line;
  logic [511:0] wmask;
  logic [511:0] wdat;
  logic [511:0] new_line;
  logic [63:0]  rd_data;
  logic [2:0]   age_next [WAYS];

  always_comb begin
    hit         = 1'b0;
    hit_way     = 3'd0;
    has_invalid = 1'b0;
    inv_way     = 3'd0;
    lru_way     = 3'd0;
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && (tag_q[w] == tag)) begin
        hit     = 1'b1;
        hit_way = 3'(w);
      end
      if (!valid_q[w]) begin
        has_invalid = 1'b1;
        inv_way     = 3'(w);
      end
      if (age_q[w] == 3'd7) begin
        lru_way = 3'(w);
      end
    end

    if (hit) begin
      acc_way = hit_way;
    end else if (has_invalid) begin
      acc_way = inv_way;
    end else begin
      acc_way = lru_way;
    end
    old_age = age_q[acc_way];

    case (data_size)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase

    bit_shift = {block_offset, 3'b000};
    // A write miss starts from a zero-filled line, so a miss simply merges into zero.
    base_line = hit ? line_q[hit_way] : 512'd0;
    // Shifting past bit 511 drops bytes beyond the end of the line on write
    // and shifts in zeros on read, so no line crossing ever happens.
    wmask     = {448'd0, size_mask} << bit_shift;
    wdat      = {448'd0, write_data} << bit_shift;
    new_line  = (base_line & ~wmask) | (wdat & wmask);
    rd_data   = 64'(base_line >> bit_shift) & size_mask;

    // Promote acc_way to MRU: every younger way ages by one, older ways keep
    // their age, so the ages stay a permutation of 0..7.
    for (int w = 0; w < WAYS; w++) begin
      if (3'(w) == acc_way) begin
        age_next[w] = 3'd0;
      end else if (age_q[w] < old_age) begin
        age_next[w] = age_q[w] + 3'd1;
      end else begin
        age_next[w] = age_q[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      rd_q     <= '0;
      miss_r_q <= 1'b0;
      miss_w_q <= 1'b0;
      rdy_q    <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        age_q[w] <= 3'(w);
      end
    end else begin
      // data_ready is a single-cycle pulse, so it drops even on idle cycles.
      rdy_q <= 1'b0;
      if (enable[0]) begin
        miss_r_q <= 1'b0;
        miss_w_q <= 1'b0;
        case (write_en)
          3'd0: begin
            rdy_q    <= 1'b1;
            miss_r_q <= ~hit;
            rd_q     <= hit ? rd_data : 64'd0;
            // A read miss allocates nothing and leaves LRU alone.
            if (hit) begin
              for (int w = 0; w < WAYS; w++) begin
                age_q[w] <= age_next[w];
              end
            end
          end
          3'd1: begin
            miss_w_q         <= ~hit;
            valid_q[acc_way] <= 1'b1;
            dirty_q[acc_way] <= 1'b1;
            tag_q[acc_way]   <= tag;
            line_q[acc_way]  <= new_line;
            for (int w = 0; w < WAYS; w++) begin
              age_q[w] <= age_next[w];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data   = {64'd0, rd_q};
  assign miss_r     = {1'b0, miss_r_q};
  assign miss_w     = {1'b0, miss_w_q};
  assign data_ready = {1'b0, rdy_q};

endmodule

// File: tb/tb_cache_set.sv
// tb_cache_set: directed bench for cache_set with a queue-based scoreboard.
// The driver pushes expected read/write outcomes; a negedge monitor pops them
// when the DUT presents a read result or a write was accepted on the prior edge.
module tb_cache_set;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   enable;
  logic [2:0]   write_en;
  logic [5:0]   block_offset;
  logic [5:0]   set_n;
  logic [63:0]  write_data;
  logic [1:0]   data_size;
  logic [23:0]  tag;
  logic [31:0]  num_ops;
  logic [127:0] out_data;
  logic [1:0]   miss_w;
  logic [1:0]   miss_r;
  logic [1:0]   data_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0] rq [$];  // {miss_r, data}
  logic        wq [$];  // miss_w
  logic        chk_r = 1'b0;
  logic        chk_w = 1'b0;

  cache_set dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .write_en     (write_en),
    .block_offset (block_offset),
    .set_n        (set_n),
    .write_data   (write_data),
    .data_size    (data_size),
    .tag          (tag),
    .num_ops      (num_ops),
    .out_data     (out_data),
    .miss_w       (miss_w),
    .miss_r       (miss_r),
    .data_ready   (data_ready)
  );

  always #5 clk = ~clk;

  // Remember which ops were accepted at each rising edge.
  always @(posedge clk) begin
    chk_r <= !reset && enable[0] && (write_en == 3'd0);
    chk_w <= !reset && enable[0] && (write_en == 3'd1);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [64:0] er;
    logic        ew;
    if (chk_w) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL wq_underflow: write accepted with no expectation queued");
      end else begin
        ew = wq.pop_front();
        if (miss_w !== {1'b0, ew}) begin
          miscompares++;
          $display("FAIL miss_w: got %b want %b", miss_w, {1'b0, ew});
        end
      end
    end
    if (chk_r && data_ready !== 2'b01) begin
      vectors++;
      miscompares++;
      $display("FAIL rdy_missing: data_ready=%b after accepted read", data_ready);
    end
    if (data_ready[0] === 1'b1) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL rdy_spurious: data_ready high with no read outstanding");
      end else begin
        er = rq.pop_front();
        if (miss_r !== {1'b0, er[64]} || out_data !== {64'd0, er[63:0]} || data_ready[1] !== 1'b0) begin
          miscompares++;
          $display("FAIL read: got miss_r=%b data=%h want miss_r=%b data=%h",
                   miss_r, out_data, {1'b0, er[64]}, {64'd0, er[63:0]});
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the op's result visible.
  task automatic op(input logic [1:0] en, input logic [2:0] we, input logic [23:0] t,
                    input logic [5:0] off, input logic [1:0] sz, input logic [63:0] d,
                    input logic exp_miss, input logic [63:0] exp_d);
    enable       = en;
    write_en     = we;
    tag          = t;
    block_offset = off;
    data_size    = sz;
    write_data   = d;
    num_ops      = num_ops + 32'd1;
    if (!reset && en[0]) begin
      if (we == 3'd0) rq.push_back({exp_miss, exp_d});
      if (we == 3'd1) wq.push_back(exp_miss);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [23:0] t, input logic [5:0] off, input logic [1:0] sz,
                    input logic [63:0] d, input logic exp_miss);
    op(2'b01, 3'd1, t, off, sz, d, exp_miss, 64'd0);
  endtask

  task automatic rd(input logic [23:0] t, input logic [5:0] off, input logic [1:0] sz,
                    input logic exp_miss, input logic [63:0] exp_d);
    op(2'b01, 3'd0, t, off, sz, 64'd0, exp_miss, exp_d);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 2'b00; write_en = 3'd2; block_offset = '0; set_n = 6'd5;
    write_data = '0; data_size = '0; tag = '0; num_ops = '0;
    @(negedge clk);
    do_reset();
    check("reset_out_data", out_data, 128'd0);
    check("reset_flags", {miss_w, miss_r, data_ready}, 6'd0);

    // Fill two ways, read hit / miss.
    wr(24'd16, 6'd0, 2'd0, 64'd3, 1'b1);
    wr(24'd25, 6'd0, 2'd0, 64'd8, 1'b1);
    rd(24'd16, 6'd0, 2'd0, 1'b0, 64'd3);
    rd(24'd19, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd19, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd25, 6'd0, 2'd0, 1'b0, 64'd8);

    // Byte merge within a dword.
    wr(24'd16, 6'd0, 2'd3, 64'h1122334455667788, 1'b0);
    wr(24'd16, 6'd1, 2'd0, 64'hAA, 1'b0);
    rd(24'd16, 6'd0, 2'd3, 1'b0, 64'h112233445566AA88);
    rd(24'd16, 6'd2, 2'd1, 1'b0, 64'h5566);

    // LRU eviction: fill all ways, touch tag1, allocate tag9 -> tag2 evicted.
    do_reset();
    for (int i = 1; i <= 8; i++) wr(24'(i), 6'd0, 2'd0, 64'(i), 1'b1);
    rd(24'd1, 6'd0, 2'd0, 1'b0, 64'd1);
    wr(24'd9, 6'd0, 2'd0, 64'd9, 1'b1);
    rd(24'd2, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd1, 6'd0, 2'd0, 1'b0, 64'd1);
    rd(24'd9, 6'd0, 2'd0, 1'b0, 64'd9);
    rd(24'd3, 6'd0, 2'd0, 1'b0, 64'd3);

    // End-of-line truncation.
    wr(24'd9, 6'd62, 2'd3, 64'h000000000000FFFF, 1'b0);
    rd(24'd9, 6'd62, 2'd3, 1'b0, 64'hFFFF);
    rd(24'd9, 6'd0, 2'd1, 1'b0, 64'h0009);
    rd(24'd9, 6'd60, 2'd2, 1'b0, 64'hFFFF0000);

    // No-op holds out_data and clears data_ready.
    op(2'b01, 3'd2, 24'd9, 6'd0, 2'd0, 64'd0, 1'b0, 64'd0);
    check("noop_hold_data", out_data, {64'd0, 64'hFFFF0000});
    check("noop_rdy", {62'd0, data_ready}, 64'd0);

    // Disabled writes are ignored.
    op(2'b00, 3'd1, 24'd40, 6'd0, 2'd0, 64'd7, 1'b0, 64'd0);
    op(2'b10, 3'd1, 24'd41, 6'd0, 2'd0, 64'd7, 1'b0, 64'd0);
    rd(24'd40, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd41, 6'd0, 2'd0, 1'b1, 64'd0);
    op(2'b01, 3'd5, 24'd41, 6'd0, 2'd0, 64'd0, 1'b0, 64'd0);
    check("noop_clears_miss_r", {62'd0, miss_r}, 64'd0);

    // Reset wins over a simultaneous write; everything misses afterwards.
    reset = 1'b1;
    op(2'b01, 3'd1, 24'd50, 6'd0, 2'd0, 64'd1, 1'b0, 64'd0);
    reset = 1'b0;
    rd(24'd50, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd9, 6'd0, 2'd0, 1'b1, 64'd0);
    rd(24'd1, 6'd0, 2'd0, 1'b1, 64'd0);

    enable = 2'b00;
    repeat (3) @(negedge clk);
    check("queues_drained", 128'(rq.size() + wq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_set.md
# cache_set

One set of an 8-way set-associative, 64-byte-line L1 data cache (64 sets × 8 ways × 64 B = 32 KiB, i7-style). Holds tag, valid, dirty and LRU state plus line data for its 8 ways. Performs byte/half/word/dword reads and writes at a byte offset, and reports hit/miss per access. Instantiated 64 times by the cache top, which decodes the set index and drives `enable`; no backing memory is attached at this level.

## Interface
- No parameters. Fixed: WAYS=8, LINE_BYTES=64, TAG_W=24.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 2: bit0=1 accepts the operation this cycle; bit1 ignored.
- `write_en` in 3: operation. 0=read, 1=write, 2=no-op (hold outputs); 3–7 treated as no-op.
- `block_offset` in 6: byte offset within line.
- `set_n` in 6: set index of this instance; debug only, no functional effect.
- `write_data` in 64: write data, right-aligned.
- `data_size` in 2: 0=8, 1=16, 2=32, 3=64 bits.
- `tag` in 24: address tag.
- `num_ops` in 32: debug operation counter; ignored functionally.
- `out_data` out 128: read data, zero-extended; bits [127:64] always 0.
- `miss_w` out 2: bit0=last write missed; bit1 always 0.
- `miss_r` out 2: bit0=last read missed; bit1 always 0.
- `data_ready` out 2: bit0=read result valid; bit1 always 0.

## Operation
- Per way: valid, dirty, 24-bit tag, 512-bit data, 3-bit LRU age. Ages always form a permutation of 0–7; 7 = least recently used.
- Hit: a valid way whose tag equals `tag`; at most one.
- Byte order is little-endian: the byte at `block_offset` is the LSB. Bytes falling past byte 63 are dropped on write and read as 0; no line crossing.
- Read hit: `out_data` = selected bytes zero-extended; `miss_r`=0; way promoted to MRU.
- Read miss: `out_data`=0; `miss_r`=1; no allocation; LRU unchanged.
- Write hit: merge the selected bytes only; dirty=1; `miss_w`=0; promote to MRU.
- Write miss (write-allocate): victim is the lowest-index invalid way, else the way with age 7. The line is zero-filled, the tag loaded, valid=1 and dirty=1, then the data merged; `miss_w`=1; promote to MRU. Victim dirty data is discarded.
- LRU promote: the accessed way's age becomes 0. Every way with age below the accessed way's old age increments.
- Any accepted read/write/no-op first clears `miss_r`, `miss_w` and `data_ready` bit0, then sets the applicable flag.
- `enable`[0]=0: no state or output change.

## Timing
- Inputs are sampled at the rising edge with `enable`[0]=1. Results are registered and visible after that edge (1-cycle latency).
- `data_ready`[0] pulses high for exactly the one cycle after an accepted read, hit or miss.
- `out_data` holds its last read value through no-ops, writes and idle cycles.
- Back-to-back operations are allowed every cycle. Each sees the state left by the previous one: read-after-write to the same tag hits.
- Reset (takes priority over any op in the same cycle):
  - all valid=0 and dirty=0; way i age = i;
  - `out_data`=0, `miss_r`=0, `miss_w`=0, `data_ready`=0;
  - tag and data contents don't care.

## Test plan
- After reset, write tag16/offset0/size0/data3, then write tag25/offset0/size0/data8 -> `miss_w`=1 after each; tag16 in way0, tag25 in way1.
- Read tag16/offset0/size0 -> next cycle `miss_r`=0, `data_ready`=1, `out_data`=3. Read tag19 -> `miss_r`=1, `out_data`=0, `data_ready`=1, and a later tag19 read still misses.
- Write 64-bit 0x1122334455667788 at offset0, write 8-bit 0xAA at offset1, read 64-bit -> `out_data`=0x112233445566AA88, `miss_w`=0 on the second write.
- Write tags 1–8 (all miss), read tag1 (hit), write tag9 -> tag2 evicted: reading tag2 misses, tag1 and tag9 hit.
- Write at offset62 size3 data 0xFFFF -> read offset62 size3 returns 0xFFFF (upper bytes dropped). With `enable`=0 a write is ignored; reset asserted mid-sequence makes every subsequent read miss.
